// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter over 2**N requesters; registered one-hot grant plus index, 1-cycle req->gnt.
// A grant is held until done, withdrawal of the owner's req, or MAX_HOLD expiry; no preemption.
module rr_grant_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2**N-1:0] req,
  input  logic            done,
  output logic [2**N-1:0] gnt,
  output logic [N-1:0]    gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int NR = 2**N;
  localparam logic [15:0] HOLD_LIM = 16'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NR-1:0]   gnt_q, gnt_d;
  logic [N-1:0]    gnt_idx_q, gnt_idx_d;
  logic [N-1:0]    last_q, last_d;
  logic [15:0]     hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;

  logic [N-1:0]    cand;
  logic [N-1:0]    winner;
  logic            found;
  logic            rel_done, rel_wd, rel_to;

  // Scan last+1, last+2, ... wrapping; the final candidate is last itself.
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NR; i++) begin
      cand = last_q + N'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign rel_done = done;
  assign rel_wd   = !req[gnt_idx_q];
  assign rel_to   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d[winner] = 1'b1;
          gnt_idx_d     = winner;
          hold_cnt_d    = '0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        hold_cnt_d = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
        if (rel_done || rel_wd || rel_to) begin
          last_d    = gnt_idx_q;
          gnt_d     = '0;
          state_d   = IDLE;
          // Flag only revocations the owner did not also ask for.
          timeout_d = rel_to && !rel_done && !rel_wd;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_q     <= '1;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == BUSY);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N=2, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_grant_arbiter #(.N(2), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                         input logic e_vld, input logic e_to);
    chk({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    chk({tag, ".gnt_idx"},   32'(gnt_idx),   32'(e_idx));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_vld));
    chk({tag, ".timeout"},   32'(timeout),   32'(e_to));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt_valid) chk("inv_onehot", 32'(gnt), 32'(4'b0001 << gnt_idx));
      else           chk("inv_idle_gnt", 32'(gnt), 32'd0);
      chk("inv_to_vld", 32'(timeout & gnt_valid), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #3;
    chk_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: idle with no requests
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // 2: all requesting, done in each grant cycle -> 0,1,2,3,0 with a gap cycle
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("rr_grant", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_out("rr_gap", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
    end
    req = '0;
    tick();

    // 3: single request then withdrawal
    do_reset();
    req = 4'b0100;
    tick();
    chk_out("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_out("withdraw", 4'b0000, 2'd2, 1'b0, 1'b0);

    // 4: timeout after 8 cycles, then regrant; then done coinciding with expiry
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk_out("hold", 4'b0001, 2'd0, 1'b1, 1'b0);
      tick();
    end
    chk_out("timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      chk_out("hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
      if (c == 8) done = 1'b1;
      tick();
    end
    done = 1'b0;
    chk_out("done_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = '0;
    tick();
    chk_out("after_limit", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 5: skip absent requester 2
    do_reset();
    req = 4'b0010;
    tick();
    chk_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req  = 4'b1011;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("rel1", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    chk_out("skip_to3", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_out("rel3", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    chk_out("wrap_to0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 6: asynchronous reset mid-grant, priority restarts at 0
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    chk_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
